// File: rtl/posit_pkg.sv
// -----------------------------------------------------------------------------
// posit_pkg
//
// Shared definitions for the posit arithmetic blocks.
//   - POSIT_N_DEFAULT / POSIT_ES_DEFAULT : default posit geometry shared with
//     the multiplier datapath (N=16, es=3).
//   - sext_state_t : state encoding of the serial field extractor.
//   - posit_log2() : ceiling log2, usable in constant expressions, used to size
//     the regime count.
// -----------------------------------------------------------------------------
package posit_pkg;

  localparam int POSIT_N_DEFAULT  = 16;
  localparam int POSIT_ES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } sext_state_t;

  // Ceiling log2 with a floor of 1 so a width derived from it is never zero.
  function automatic int posit_log2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/posit_serial_extract.sv
// -----------------------------------------------------------------------------
// posit_serial_extract
//
// Field-decode stage in front of the posit multiplier. It accepts one raw
// posit per valid/ready handshake and takes its two's-complement magnitude.
// It then walks the regime run one bit per clock, and presents the decoded
// fields in the format the multiplier datapath consumes. A single shift
// register and counter stand in for a combinational leading-count/shifter, so
// this block trades latency for area.
//
// Parameters
//   N   posit width (default 16)
//   es  exponent field width, legal range 1..N-3 (default 3)
//   Bs  regime count width, derived from N (not overridable)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   raw posit on in_posit is valid
//   in_ready   block can accept a posit this cycle
//   in_posit   raw posit [N-1:0]
//   out_valid  decoded fields are valid, held until out_ready
//   out_ready  consumer takes the fields
//   sign       sign bit of the raw posit
//   zero       input was all zeros
//   inf        input was 1 followed by N-1 zeros (NaR)
//   rc         regime polarity (first regime bit of the magnitude)
//   regime     run-1 when rc=1, run when rc=0
//   exp        exponent field, zero-padded when truncated by the regime
//   mant       fraction bits, left-aligned, zero-padded [N-es-1:0]
//
// Build option
//   POSIT_SEXT_B2B_EN  when defined, a new posit may be accepted on the same
//                      edge that drains the current result (no idle bubble).
//                      When undefined, one idle cycle separates the drain of a
//                      result from the next acceptance.
//
// Latency: the zero/NaR fast path shows out_valid right after the accepting
// edge. Any other posit shows it run+1 edges later, at most N edges (0x7FFF at
// N=16).
// -----------------------------------------------------------------------------
module posit_serial_extract
  import posit_pkg::*;
#(
  parameter  int N  = POSIT_N_DEFAULT,
  parameter  int es = POSIT_ES_DEFAULT,
  localparam int Bs = posit_log2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_posit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sign,
  output logic            zero,
  output logic            inf,
  output logic            rc,
  output logic [Bs-1:0]   regime,
  output logic [es-1:0]   exp,
  output logic [N-es-1:0] mant
);

  // The run can never be longer than N-1 bits, so the scan stops there even
  // if the terminator is never seen.
  localparam logic [Bs-1:0] CNT_LIMIT = Bs'(N - 1);

  sext_state_t state_q;
  sext_state_t state_d;

  logic [N-1:0]  sh_q;
  logic [Bs-1:0] cnt_q;
  logic [N-2:0]  abs_low;
  logic [N-1:0]  rem;
  logic          fast_path;
  logic          accept;
  logic          scan_step;
  logic          scan_done;

  // Only the low N-1 bits of the magnitude are needed. The low bits of a
  // two's-complement negation depend only on the low bits of the operand. The
  // one input whose magnitude would set the MSB (1000..0) takes the fast path.
  assign abs_low   = in_posit[N-1] ? (~in_posit[N-2:0] + (N-1)'(1)) : in_posit[N-2:0];
  assign fast_path = (in_posit[N-2:0] == '0);

  // Bits that follow the terminator. The terminator itself sits in sh_q[N-1]
  // and is dropped.
  assign rem       = {sh_q[N-2:0], 1'b0};

  assign out_valid = (state_q == ST_OUT);

  // State register. Reset aborts any scan in progress, and no result is
  // emitted for the posit that was being decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode. A scan step continues while the bit at
  // the top of the shifter still matches the regime polarity. The first
  // mismatch, or running out of bits, ends the scan and moves to OUT.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    scan_step = 1'b0;
    scan_done = 1'b0;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SCAN: begin
        if ((sh_q[N-1] == rc) && (cnt_q < CNT_LIMIT)) begin
          scan_step = 1'b1;
        end else begin
          scan_done = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
`ifdef POSIT_SEXT_B2B_EN
        in_ready = out_ready;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    accept = in_valid && in_ready;
    if (accept) begin
      state_d = fast_path ? ST_OUT : ST_SCAN;
    end
  end

  // Field and scan datapath. On acceptance the fields are cleared, and only
  // zero/inf/sign are meaningful on the fast path. Otherwise the shifter is
  // loaded with the magnitude with its MSB already consumed, so sh_q[N-1] is
  // the first regime bit. When the scan ends, the bits after the terminator
  // split into exp (top es bits) and mant (the rest). Both are zero-padded by
  // the left shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      sign   <= 1'b0;
      zero   <= 1'b0;
      inf    <= 1'b0;
      rc     <= 1'b0;
      regime <= '0;
      exp    <= '0;
      mant   <= '0;
    end else if (accept) begin
      sign   <= in_posit[N-1];
      zero   <= fast_path & ~in_posit[N-1];
      inf    <= fast_path &  in_posit[N-1];
      rc     <= fast_path ? 1'b0 : abs_low[N-2];
      regime <= '0;
      exp    <= '0;
      mant   <= '0;
      sh_q   <= {abs_low, 1'b0};
      cnt_q  <= '0;
    end else if (scan_step) begin
      sh_q   <= {sh_q[N-2:0], 1'b0};
      cnt_q  <= cnt_q + Bs'(1);
    end else if (scan_done) begin
      // cnt_q equals the run length here. For rc=1 the run is at least one,
      // because the first regime bit matched.
      exp    <= rem[N-1 -: es];
      mant   <= rem[N-es-1:0];
      regime <= rc ? (cnt_q - Bs'(1)) : cnt_q;
    end
  end

endmodule

// File: tb/tb_posit_serial_extract.sv
// -----------------------------------------------------------------------------
// tb_posit_serial_extract
//
// Self-checking bench for posit_serial_extract at N=16, es=3. Expected fields
// and latencies come from a reference model that decodes the posit
// arithmetically: it takes the magnitude, measures the regime run, and slices
// the remaining bits. Directed cases are followed by randomized posits, a
// result-hold check, a drain/accept overlap check and a mid-scan reset abort.
// Honours POSIT_SEXT_B2B_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_posit_serial_extract;

  localparam int N  = 16;
  localparam int ES = 3;
  localparam int BS = 4;
  localparam int MAX_WAIT = 40;

  typedef struct {
    int sign;
    int zero;
    int inf;
    int rc;
    int regime;
    int ex;
    int mant;
    int lat;
  } fields_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_posit;
  logic            out_valid;
  logic            out_ready;
  logic            sign;
  logic            zero;
  logic            inf;
  logic            rc;
  logic [BS-1:0]   regime;
  logic [ES-1:0]   expField;
  logic [N-ES-1:0] mant;

  int          checkCount;
  int          errCount;
  logic [N-1:0] curPosit;
  fields_t     expect_f;

  posit_serial_extract #(.N(N), .es(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .zero      (zero),
    .inf       (inf),
    .rc        (rc),
    .regime    (regime),
    .exp       (expField),
    .mant      (mant)
  );

  // 10-unit clock. Inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung handshake.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Decode a posit directly from its definition: magnitude, run of identical
  // regime bits, then the bits after the terminator.
  function automatic fields_t refModel(input logic [N-1:0] p);
    fields_t f;
    int absv;
    int run;
    int rem;
    f.sign = int'(p[N-1]);
    f.zero = 0; f.inf = 0; f.rc = 0; f.regime = 0; f.ex = 0; f.mant = 0; f.lat = 0;
    if ((int'(p) % (1 << (N - 1))) == 0) begin
      f.zero = (p[N-1] == 1'b0) ? 1 : 0;
      f.inf  = (p[N-1] == 1'b1) ? 1 : 0;
      return f;
    end
    absv = p[N-1] ? ((1 << N) - int'(p)) : int'(p);
    f.rc = (absv >> (N - 2)) & 1;
    run  = 0;
    while ((run < N - 1) && (((absv >> (N - 2 - run)) & 1) == f.rc)) begin
      run++;
    end
    f.regime = (f.rc == 1) ? run - 1 : run;
    rem      = (absv << (run + 2)) & ((1 << N) - 1);
    f.ex     = rem >> (N - ES);
    f.mant   = rem & ((1 << (N - ES)) - 1);
    f.lat    = run + 1;
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: posit=0x%04h got 0x%0h expected 0x%0h", tag, curPosit, observed, expected);
    end
  endtask

  // Wait (bounded) for in_ready at a falling edge, present the posit and
  // return at the falling edge after the accepting rising edge.
  task automatic startPosit(input logic [N-1:0] p);
    int waited;
    waited = 0;
    while (!in_ready && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    curPosit = p;
    expect_f = refModel(p);
    in_valid = 1'b1;
    in_posit = p;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_posit = N'($urandom);
  endtask

  // Count edges until out_valid, then compare every field with the model.
  task automatic waitAndCheck();
    int edges;
    edges = 0;
    while (!out_valid && edges < MAX_WAIT) begin
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'(expect_f.lat));
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("sign", 32'(sign), 32'(expect_f.sign));
    checkOutput("zero", 32'(zero), 32'(expect_f.zero));
    checkOutput("inf", 32'(inf), 32'(expect_f.inf));
    checkOutput("rc", 32'(rc), 32'(expect_f.rc));
    checkOutput("regime", 32'(regime), 32'(expect_f.regime));
    checkOutput("exp", 32'(expField), 32'(expect_f.ex));
    checkOutput("mant", 32'(mant), 32'(expect_f.mant));
  endtask

  // Hold the result with out_ready low, then drain it and confirm the block
  // returns to idle.
  task automatic holdAndDrain(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_regime", 32'(regime), 32'(expect_f.regime));
      checkOutput("hold_exp", 32'(expField), 32'(expect_f.ex));
      checkOutput("hold_mant", 32'(mant), 32'(expect_f.mant));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [N-1:0] p, input int hold);
    startPosit(p);
    waitAndCheck();
    holdAndDrain(hold);
  endtask

  initial begin
    logic [N-1:0] directed [9];
    logic         sawValid;
    checkCount = 0;
    errCount   = 0;
    curPosit   = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_posit   = '0;
    out_ready  = 1'b0;

    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_regime", 32'(regime), 32'd0);
    checkOutput("reset_mant", 32'(mant), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed posits");
    directed = '{16'h4000, 16'h2A5F, 16'hC000, 16'h7FFF, 16'h0000,
                 16'h8000, 16'h0001, 16'hFFFF, 16'h8001};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(directed[i], (i == 1) ? 5 : 0);
    end

    $display("[TB] randomized posits");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(N'($urandom_range(0, 16'hFFFF)), $urandom_range(0, 3));
    end

    $display("[TB] drain overlapped with a new request");
    startPosit(16'h2A5F);
    waitAndCheck();
    in_valid  = 1'b1;
    in_posit  = 16'h4000;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
`ifdef POSIT_SEXT_B2B_EN
    in_valid = 1'b0;
    checkOutput("b2b_valid", 32'(out_valid), 32'd0);
    checkOutput("b2b_in_ready", 32'(in_ready), 32'd0);
`else
    checkOutput("bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("bubble_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
`endif
    curPosit = 16'h4000;
    expect_f = refModel(16'h4000);
    waitAndCheck();
    holdAndDrain(1);

    $display("[TB] reset in the middle of a scan");
    startPosit(16'h7FFF);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_regime", 32'(regime), 32'd0);
    #1 rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_result", 32'(sawValid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h4000, 2);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
